// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps at most one request
// outstanding to instruction memory, buffers one returned instruction for the
// decode stage, and drops any stale in-flight fetch after a redirect.
module ifu_fetch_ctrl #(
    parameter int unsigned          CPU_WIDTH = 64,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_imem_req_valid,
    input  logic                 i_imem_req_ready,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_rsp_valid,
    output logic                 o_imem_rsp_ready,
    input  logic [31:0]          i_imem_rsp_data,
    output logic                 o_ifu_valid,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic [31:0]          o_ifu_inst,
    input  logic                 i_idu_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [CPU_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]          buf_inst_q, buf_inst_d;

    logic buf_free;
    logic req_hs;
    logic rsp_hs;
    logic buf_load;

    // The buffer can take a new instruction if it is empty or drains this cycle.
    assign buf_free = !buf_valid_q || i_idu_ready;
    assign req_hs   = o_imem_req_valid && i_imem_req_ready;
    assign rsp_hs   = o_imem_rsp_ready && i_imem_rsp_valid;
    // Only a live response in WAIT fills the buffer; a redirect in the same
    // cycle turns it into a discarded one.
    assign buf_load = (state_q == ST_WAIT) && rsp_hs && !i_redirect;

    assign o_imem_addr = {pc_q[CPU_WIDTH-1:2], 2'b00};
    assign o_ifu_valid = buf_valid_q;
    assign o_ifu_pc    = buf_pc_q;
    assign o_ifu_inst  = buf_inst_q;

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before this edge.
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a redirect only decides whether a stale response is owed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_hs) state_d = i_redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_hs)          state_d = ST_REQ;
                else if (i_redirect) state_d = ST_DROP;
            end
            ST_DROP: begin
                // A redirect here changes nothing: the one owed response still
                // has to be drained, and once it arrives nothing is owed.
                if (rsp_hs) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory handshake outputs decoded from state and buffer occupancy only.
    always_comb begin
        o_imem_req_valid = 1'b0;
        o_imem_rsp_ready = 1'b0;
        unique case (state_q)
            ST_REQ:  o_imem_req_valid = buf_free;
            ST_WAIT: o_imem_rsp_ready = buf_free;
            ST_DROP: o_imem_rsp_ready = 1'b1;
            default: ;
        endcase
    end

    // Next values for the PC, outstanding-request PC and output buffer.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;

        if (req_hs) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + CPU_WIDTH'(4);
        end

        if (buf_load) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = req_pc_q;
            buf_inst_d  = i_imem_rsp_data;
        end else if (buf_valid_q && i_idu_ready) begin
            buf_valid_d = 1'b0;
        end

        // Redirect wins over the sequential PC step and any buffer update.
        if (i_redirect) begin
            pc_d        = i_redirect_pc;
            buf_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            // NOTE: the buffer payload is reset as well so the decode side sees
            // a defined PC/instruction of zero straight out of reset.
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-level reference model.
module tb_ifu_fetch_ctrl;

    localparam int          W      = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  imem_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          ifu_valid;
    logic [W-1:0]  ifu_pc;
    logic [31:0]   ifu_inst;
    logic          idu_ready;

    ifu_fetch_ctrl #(.CPU_WIDTH(W), .RESET_PC(RST_PC)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (imem_addr),
        .i_imem_rsp_valid (rsp_valid),
        .o_imem_rsp_ready (rsp_ready),
        .i_imem_rsp_data  (rsp_data),
        .o_ifu_valid      (ifu_valid),
        .o_ifu_pc         (ifu_pc),
        .o_ifu_inst       (ifu_inst),
        .i_idu_ready      (idu_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction word the memory returns for a given aligned address.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Reference model: fetch PC, one outstanding fetch (possibly stale), buffer.
    logic          m_idle, m_out, m_stale, m_bv;
    logic [63:0]   m_pc, m_req_pc, m_bpc;
    logic [31:0]   m_binst;

    // Memory environment: one request in service, answered after a latency.
    logic          mem_busy;
    int            mem_delay;
    logic [63:0]   mem_addr;
    int            lat = 0;   // fixed response latency, or -1 for random 0..3

    logic [63:0]   req_log[$];
    logic [63:0]   ifu_log[$];

    task automatic model_reset();
        m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
        m_pc = RST_PC; m_req_pc = '0; m_bpc = '0; m_binst = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; idu_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        mem_busy = 1'b0; mem_delay = 0; mem_addr = '0;
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            check("rst_req_valid", 64'(req_valid), 64'd0);
            check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
            check("rst_ifu_valid", 64'(ifu_valid), 64'd0);
            check("rst_ifu_pc",    ifu_pc,         64'd0);
            check("rst_ifu_inst",  64'(ifu_inst),  64'd0);
            check("rst_addr",      imem_addr,      RST_PC);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic pred_req_hs();
        return !m_idle && !m_out && (!m_bv || idu_ready) && req_ready;
    endfunction

    // One clock cycle: compare DUT outputs to the model, then advance both.
    task automatic cycle(input logic rdr, input logic [63:0] tgt);
        logic e_free, e_req, e_rsp, rq_hs, rs_hs, load, nx_out, nx_stale;
        logic d_req_hs, d_rsp_hs;
        logic [63:0] a;
        redirect    = rdr;
        redirect_pc = tgt;
        e_free = !m_bv || idu_ready;
        e_req  = !m_idle && !m_out && e_free;
        e_rsp  = m_out && (m_stale || e_free);
        @(negedge clk);
        check("req_valid", 64'(req_valid), 64'(e_req));
        check("rsp_ready", 64'(rsp_ready), 64'(e_rsp));
        check("imem_addr", imem_addr, {m_pc[63:2], 2'b00});
        check("ifu_valid", 64'(ifu_valid), 64'(m_bv));
        if (m_bv) begin
            check("ifu_pc",   ifu_pc,         m_bpc);
            check("ifu_inst", 64'(ifu_inst),  64'(m_binst));
        end
        a        = imem_addr;
        d_req_hs = req_valid && req_ready;
        d_rsp_hs = rsp_ready && rsp_valid;
        if (d_req_hs) req_log.push_back(a);
        if (ifu_valid && idu_ready) ifu_log.push_back(ifu_pc);
        rq_hs = e_req && req_ready;
        rs_hs = e_rsp && rsp_valid;
        @(posedge clk); #1;

        load     = rs_hs && !m_stale && !rdr;
        nx_out   = (m_out && !rs_hs) || rq_hs;
        nx_stale = nx_out && (rdr || (m_stale && !rs_hs));
        if (rdr) m_bv = 1'b0;
        else if (load) begin
            m_bv    = 1'b1;
            m_bpc   = m_req_pc;
            m_binst = inst_of({m_req_pc[63:2], 2'b00});
        end else if (m_bv && idu_ready) m_bv = 1'b0;
        if (rq_hs) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 64'd4;
        end
        if (rdr) m_pc = tgt;
        m_idle  = 1'b0;
        m_out   = nx_out;
        m_stale = nx_stale;

        if (d_rsp_hs) mem_busy = 1'b0;
        else if (mem_busy && mem_delay > 0) mem_delay--;
        if (d_req_hs) begin
            mem_busy  = 1'b1;
            mem_addr  = a;
            mem_delay = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        end
        rsp_valid = mem_busy && (mem_delay == 0);
        rsp_data  = rsp_valid ? inst_of(mem_addr) : $urandom;
    endtask

    task automatic clear_logs();
        req_log.delete();
        ifu_log.delete();
    endtask

    initial begin
        logic reached;

        // Straight-line fetch with zero-wait memory.
        do_reset();
        lat = 0; req_ready = 1'b1; idu_ready = 1'b1; clear_logs();
        repeat (10) cycle(1'b0, '0);
        check("s1_nreq", 64'(req_log.size() >= 3), 64'd1);
        check("s1_nifu", 64'(ifu_log.size() >= 3), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < req_log.size()) check("s1_req_addr", req_log[i], RST_PC + 64'(4 * i));
            if (i < ifu_log.size()) check("s1_ifu_pc",   ifu_log[i], RST_PC + 64'(4 * i));
        end

        // Decode back-pressure for 5 cycles once the first instruction is held.
        do_reset();
        lat = 0; req_ready = 1'b1; idu_ready = 1'b0; clear_logs();
        for (int i = 0; i < 20; i++) begin
            if (m_bv) break;
            cycle(1'b0, '0);
        end
        check("s2_filled", 64'(ifu_valid), 64'd1);
        repeat (5) begin
            cycle(1'b0, '0);
            check("s2_held_pc", ifu_pc, RST_PC);
        end
        idu_ready = 1'b1;
        repeat (12) cycle(1'b0, '0);
        check("s2_nifu", 64'(ifu_log.size() >= 4), 64'd1);
        for (int i = 0; i < ifu_log.size(); i++)
            check("s2_ifu_seq", ifu_log[i], RST_PC + 64'(4 * i));

        // Redirect while waiting on a slow response.
        do_reset();
        lat = 3; req_ready = 1'b1; idu_ready = 1'b1; reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_out && m_req_pc == RST_PC + 64'd4) begin reached = 1'b1; break; end
            cycle(1'b0, '0);
        end
        check("s3_reached", 64'(reached), 64'd1);
        cycle(1'b1, 64'h8000_0100);
        clear_logs();
        repeat (20) cycle(1'b0, '0);
        check("s3_nreq", 64'(req_log.size() >= 1), 64'd1);
        check("s3_nifu", 64'(ifu_log.size() >= 1), 64'd1);
        if (req_log.size() > 0) check("s3_req_target", req_log[0], 64'h8000_0100);
        if (ifu_log.size() > 0) check("s3_ifu_target", ifu_log[0], 64'h8000_0100);

        // Redirect coinciding with a request handshake.
        do_reset();
        lat = 0; req_ready = 1'b1; idu_ready = 1'b1; reached = 1'b0;
        repeat (3) cycle(1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            if (pred_req_hs()) begin reached = 1'b1; break; end
            cycle(1'b0, '0);
        end
        check("s4_reached", 64'(reached), 64'd1);
        cycle(1'b1, 64'h8000_0200);
        clear_logs();
        repeat (10) cycle(1'b0, '0);
        if (req_log.size() > 0) check("s4_req_target", req_log[0], 64'h8000_0200);
        if (ifu_log.size() > 0) check("s4_ifu_target", ifu_log[0], 64'h8000_0200);
        check("s4_nifu", 64'(ifu_log.size() >= 1), 64'd1);

        // Redirect coinciding with a response handshake.
        do_reset();
        lat = 1; req_ready = 1'b1; idu_ready = 1'b1; reached = 1'b0;
        repeat (6) cycle(1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            if (m_out && !m_stale && rsp_valid) begin reached = 1'b1; break; end
            cycle(1'b0, '0);
        end
        check("s5_reached", 64'(reached), 64'd1);
        cycle(1'b1, 64'h8000_0300);
        check("s5_ifu_empty", 64'(ifu_valid), 64'd0);
        clear_logs();
        cycle(1'b0, '0);
        check("s5_next_req", req_log.size() > 0 ? req_log[0] : 64'd0, 64'h8000_0300);

        // Misaligned redirect target.
        do_reset();
        lat = 0; req_ready = 1'b0; idu_ready = 1'b1;
        cycle(1'b0, '0);
        cycle(1'b1, 64'h8000_0102);
        clear_logs();
        req_ready = 1'b1;
        repeat (8) cycle(1'b0, '0);
        check("s6_nreq", 64'(req_log.size() >= 2), 64'd1);
        check("s6_nifu", 64'(ifu_log.size() >= 2), 64'd1);
        if (req_log.size() >= 2) begin
            check("s6_addr0", req_log[0], 64'h8000_0100);
            check("s6_addr1", req_log[1], 64'h8000_0104);
        end
        if (ifu_log.size() >= 2) begin
            check("s6_pc0", ifu_log[0], 64'h8000_0102);
            check("s6_pc1", ifu_log[1], 64'h8000_0106);
        end

        // Randomized traffic with occasional mid-flight resets.
        do_reset();
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        rdr;
            logic [63:0] tgt;
            if ($urandom_range(0, 399) == 0) do_reset();
            idu_ready = ($urandom_range(0, 3) != 0);
            req_ready = ($urandom_range(0, 2) != 0);
            rdr       = ($urandom_range(0, 9) == 0);
            tgt       = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            cycle(rdr, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller at the front of the pipeline. It owns the architectural fetch PC and issues single-outstanding fetch requests to instruction memory over a valid/ready interface. It buffers one returned instruction for the ID stage. When the ID-stage branch unit signals a jump, it redirects to the target PC and discards any stale in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default `64'h8000_0000`: fetch PC loaded on reset.

Ports:
- `i_clk`  in  1  clock; all logic is rising-edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_redirect`  in  1  branch-unit jump/flush pulse; same meaning as the branch unit's IF/ID nop.
- `i_redirect_pc`  in  `CPU_WIDTH`  jump target; valid when `i_redirect`=1.
- `o_imem_req_valid`  out  1  fetch request valid.
- `i_imem_req_ready`  in  1  memory accepts the request.
- `o_imem_addr`  out  `CPU_WIDTH`  fetch address; equals the PC with bits [1:0] forced to 0.
- `i_imem_rsp_valid`  in  1  response valid.
- `o_imem_rsp_ready`  out  1  controller accepts the response.
- `i_imem_rsp_data`  in  32  fetched instruction.
- `o_ifu_valid`  out  1  buffered instruction valid toward the IDU.
- `o_ifu_pc`  out  `CPU_WIDTH`  PC of the buffered instruction.
- `o_ifu_inst`  out  32  buffered instruction.
- `i_idu_ready`  in  1  IDU consumes the buffer this cycle when `o_ifu_valid`=1.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `buf_valid`, `buf_pc`, `buf_inst`: one-entry output buffer.
  - `req_pc`: address of the outstanding request.
  - `state`: one of IDLE, REQ, WAIT, DROP.
- Buffer "free" is defined as `!buf_valid || i_idu_ready`.
- IDLE (reset state):
  - No request is issued.
  - Next state is always REQ.
- REQ:
  - `o_imem_req_valid` = free.
  - On the request handshake: `req_pc`<=`pc`, `pc`<=`pc`+4 (modulo 2^`CPU_WIDTH`), and the state goes to WAIT.
- WAIT:
  - `o_imem_rsp_ready` = free.
  - On the response handshake: the buffer loads {`req_pc`, `i_imem_rsp_data`}, `buf_valid`<=1, and the state goes to REQ.
- DROP:
  - `o_imem_rsp_ready`=1.
  - The response handshake discards the data and moves the state to REQ.
- Consume:
  - `o_ifu_valid && i_idu_ready` with no new load gives `buf_valid`<=0.
  - Load and consume in the same cycle gives `buf_valid` stays 1 with the new contents.
- Redirect (`i_redirect`=1) overrides every other update in the same cycle:
  - `pc` <= `i_redirect_pc`.
  - `buf_valid` <= 0; the IDU consume that cycle is irrelevant.
  - IDLE: next state is REQ.
  - REQ with no handshake that cycle: stay in REQ.
  - REQ with a handshake that cycle: go to DROP. `o_imem_req_valid` is not gated by `i_redirect`, so no combinational path exists from the redirect input to the memory request.
  - WAIT with no response that cycle: go to DROP.
  - WAIT with a response that cycle: the response is discarded, not loaded; go to REQ.
  - DROP: stay in DROP, because the stale response is still owed.
- At most one request is outstanding. The response order matches the request order.
- Misaligned redirect targets: bits [1:0] are carried in `pc` but cleared on `o_imem_addr`. No exception is raised.

## Timing
- While `i_rst`=1 and on the first edge after it:
  - `state`=IDLE, `pc`=`RESET_PC`, `buf_valid`=0.
  - `o_imem_req_valid`=0, `o_imem_rsp_ready`=0, `o_ifu_valid`=0.
  - `o_ifu_pc`=0 and `o_ifu_inst`=0 (buffer data registers reset to 0).
- The first request is asserted in the 2nd cycle after `i_rst` falls, with address `RESET_PC`.
- Zero-wait memory (ready=1, response the cycle after acceptance):
  - Request accepted in cycle N, response in N+1, `o_ifu_valid`=1 in N+2.
  - The next request issues in N+2.
  - Throughput is one instruction per 2 cycles.
- Redirect in cycle R:
  - `o_ifu_valid`=0 from R+1.
  - The first request to the target issues in R+1 if the state was REQ/IDLE with no handshake in R, or in WAIT with a response in R.
  - Otherwise it issues the cycle after the stale response is drained.
- Reset asserted mid-WAIT or mid-DROP:
  - The controller returns to IDLE.
  - The memory side is reset together with the controller; no stale response is expected after reset.
- All outputs are registered or decoded from `state` plus `buf_valid` and `i_idu_ready`. There is no input-to-output path from `i_redirect` or `i_imem_rsp_*`.

## Test plan
- Reset release, memory always ready, 1-cycle response, `i_idu_ready`=1:
  - Addresses requested are 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - `o_ifu_pc` follows the same sequence, with valid every 2nd cycle.
- `i_idu_ready`=0 for 5 cycles after the first instruction is buffered:
  - `o_ifu_valid`, `o_ifu_pc` and `o_ifu_inst` are held.
  - The second response is back-pressured (`o_imem_rsp_ready`=0).
  - Nothing is lost or duplicated after ready returns.
- Redirect to 0x8000_0100 while in WAIT, memory response delayed 3 cycles:
  - The stale response (0x8000_0004 data) is dropped.
  - The next request address is 0x8000_0100.
  - `o_ifu_valid` is 0 until that instruction arrives.
- Redirect in the same cycle as a request handshake:
  - The state enters DROP, one response is discarded, and the next request goes to the target.
- Redirect in the same cycle as a response while the buffer is full and the IDU is ready:
  - The buffer is emptied and the response is discarded.
  - The next cycle requests the target.
- Redirect to 0x8000_0102:
  - `o_imem_addr`=0x8000_0100, `o_ifu_pc`=0x8000_0102.
  - The next request is 0x8000_0106 with `o_imem_addr` 0x8000_0104.
